// File: rtl/frame_downsampler.sv
// Crops a window from a gray pixel stream and averages BLKxBLK blocks into an OUT_WxOUT_H image.
// One write per block, registered 1 clk after the completing pixel; no backpressure on input or output.
module frame_downsampler #(
  parameter int IN_W      = 640,
  parameter int IN_H      = 480,
  parameter int PIX_W     = 12,
  parameter int OUT_W     = 28,
  parameter int OUT_H     = 28,
  parameter int BLK_LOG2  = 4,
  parameter int X0        = 96,
  parameter int Y0        = 16,
  parameter int OUT_PIX_W = 8,
  parameter int ADDR_W    = $clog2(OUT_W*OUT_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 invert,
  input  logic                 thr_en,
  input  logic [OUT_PIX_W-1:0] thresh,
  input  logic                 pix_valid,
  input  logic                 sof,
  input  logic [PIX_W-1:0]     pix,
  output logic                 we,
  output logic [ADDR_W-1:0]    waddr,
  output logic [OUT_PIX_W-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int BLK   = 1 << BLK_LOG2;
  localparam int ACC_W = PIX_W + 2*BLK_LOG2;
  localparam int XW    = $clog2(IN_W + 1);
  localparam int YW    = $clog2(IN_H + 1);
  localparam int OX_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int SHIFT = 2*BLK_LOG2 + PIX_W - OUT_PIX_W;

  localparam logic [XW-1:0]     X_LO      = XW'(X0);
  localparam logic [XW-1:0]     X_HI      = XW'(X0 + OUT_W*BLK);
  localparam logic [XW-1:0]     X_LAST    = XW'(IN_W - 1);
  localparam logic [YW-1:0]     Y_LO      = YW'(Y0);
  localparam logic [YW-1:0]     Y_HI      = YW'(Y0 + OUT_H*BLK);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W*OUT_H - 1);

  if ((X0 + OUT_W*BLK > IN_W) || (Y0 + OUT_H*BLK > IN_H) || (OUT_PIX_W > PIX_W)) begin : g_bad_geometry
    $error("frame_downsampler: crop window exceeds input frame or OUT_PIX_W > PIX_W");
  end

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ACC_W-1:0]      acc_q [OUT_W];
  logic [ACC_W-1:0]      acc_d [OUT_W];
  logic [ADDR_W-1:0]     wcnt_q, wcnt_d;
  logic                  inv_q, inv_d, thr_en_q, thr_en_d;
  logic [OUT_PIX_W-1:0]  thresh_q, thresh_d;
  logic                  we_q, we_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [OUT_PIX_W-1:0]  wdata_q, wdata_d;

  logic                  in_win, blk_end, take;
  logic [XW-1:0]         rel_x;
  logic [BLK_LOG2-1:0]   ry;
  logic [OX_W-1:0]       ox;
  logic [ACC_W-1:0]      sum;
  logic [OUT_PIX_W-1:0]  v_raw, v_inv, v_out;

  assign rel_x   = x_q - X_LO;
  assign ry      = BLK_LOG2'(y_q - Y_LO);
  assign ox      = OX_W'(rel_x >> BLK_LOG2);
  assign in_win  = (x_q >= X_LO) && (x_q < X_HI) && (y_q >= Y_LO) && (y_q < Y_HI);
  assign blk_end = (&rel_x[BLK_LOG2-1:0]) && (&ry);
  assign take    = pix_valid && (((state_q == WAIT_SOF) && sof) || ((state_q == CAPTURE) && !sof));
  assign sum     = acc_q[ox] + ACC_W'(pix);
  // Average and keep the top OUT_PIX_W bits of the PIX_W-wide mean in one shift.
  assign v_raw   = OUT_PIX_W'(sum >> SHIFT);
  assign v_inv   = inv_q ? ~v_raw : v_raw;
  assign v_out   = thr_en_q ? ((v_inv >= thresh_q) ? '1 : '0) : v_inv;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    wcnt_d   = wcnt_q;
    inv_d    = inv_q;
    thr_en_d = thr_en_q;
    thresh_d = thresh_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WAIT_SOF;
          inv_d    = invert;
          thr_en_d = thr_en;
          thresh_d = thresh;
          err_d    = 1'b0;
          x_d      = '0;
          y_d      = '0;
          wcnt_d   = '0;
          for (int i = 0; i < OUT_W; i++) acc_d[i] = '0;
        end
      end
      WAIT_SOF, CAPTURE: begin
        if ((state_q == CAPTURE) && pix_valid && sof) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (take) begin
          state_d = CAPTURE;
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
          if (in_win) begin
            if (blk_end) begin
              acc_d[ox] = '0;
              we_d      = 1'b1;
              waddr_d   = wcnt_q;
              wdata_d   = v_out;
              wcnt_d    = wcnt_q + 1'b1;
              if (wcnt_q == LAST_ADDR) state_d = DONE;
            end else begin
              acc_d[ox] = sum;
            end
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      for (int i = 0; i < OUT_W; i++) acc_q[i] <= '0;
      wcnt_q   <= '0;
      inv_q    <= 1'b0;
      thr_en_q <= 1'b0;
      thresh_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      inv_q    <= inv_d;
      thr_en_q <= thr_en_d;
      thresh_q <= thresh_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign done  = done_q;
  assign err   = err_q;
  assign busy  = (state_q == WAIT_SOF) || (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_downsampler.sv
// Directed bench for frame_downsampler on a reduced 40x36 frame, 4x3 output of 4x4 blocks.
module tb_frame_downsampler;

  localparam int IN_W = 40, IN_H = 36, PIX_W = 12, OUT_W = 4, OUT_H = 3;
  localparam int BLK_LOG2 = 2, X0 = 6, Y0 = 5, OUT_PIX_W = 8;
  localparam int ADDR_W = $clog2(OUT_W*OUT_H);
  localparam int TOTAL = OUT_W*OUT_H;

  logic                 clk = 1'b0;
  logic                 rst, start, invert, thr_en, pix_valid, sof;
  logic [OUT_PIX_W-1:0] thresh;
  logic [PIX_W-1:0]     pix;
  logic                 we, busy, done, err;
  logic [ADDR_W-1:0]    waddr;
  logic [OUT_PIX_W-1:0] wdata;

  frame_downsampler #(
    .IN_W(IN_W), .IN_H(IN_H), .PIX_W(PIX_W), .OUT_W(OUT_W), .OUT_H(OUT_H),
    .BLK_LOG2(BLK_LOG2), .X0(X0), .Y0(Y0), .OUT_PIX_W(OUT_PIX_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .invert(invert), .thr_en(thr_en), .thresh(thresh),
    .pix_valid(pix_valid), .sof(sof), .pix(pix), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int done_cnt = 0, done_cyc = -1, last_we_cyc = -1;
  logic [ADDR_W-1:0]    wa_q [$];
  logic [OUT_PIX_W-1:0] wd_q [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      last_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_we_cyc = -1;
  endtask

  // Mode inputs are scrambled after the start pulse so only the latched copy matters.
  task automatic do_start(input bit inv, input bit te, input logic [7:0] th);
    invert = inv; thr_en = te; thresh = th; start = 1'b1;
    tick();
    start = 1'b0; invert = ~inv; thr_en = ~te; thresh = ~th;
    chk("busy_after_start", busy, 1);
  endtask

  // ramp=1 drives pix = x*16, else the constant pv.
  task automatic send_frame(input bit ramp, input logic [11:0] pv, input int sof_line,
                            input bit gaps, input int start_at, input int rst_at);
    for (int y = 0; y < IN_H; y++) begin
      for (int x = 0; x < IN_W; x++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          pix_valid = 1'b0; sof = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        pix_valid = 1'b1;
        sof   = (x == 0) && (y == 0 || y == sof_line);
        pix   = ramp ? 12'(x*16) : pv;
        start = (y*IN_W + x == start_at);
        tick();
        start = 1'b0;
        if (sof_line > 0 && y == sof_line && x == 0) begin
          chk("err_after_sof", err, 1);
          chk("busy_after_sof", busy, 0);
        end
        if (rst_at > 0 && wa_q.size() >= rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_we", we, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_err", err, 0);
          pix_valid = 1'b0; sof = 1'b0;
          tick(); tick();
          rst = 1'b0;
          tick();
          return;
        end
      end
    end
    pix_valid = 1'b0; sof = 1'b0;
    repeat (6) tick();
  endtask

  task automatic check_frame(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] ecol [OUT_W];
    int n;
    ecol[0] = e0; ecol[1] = e1; ecol[2] = e2; ecol[3] = e3;
    n = (wa_q.size() < TOTAL) ? wa_q.size() : TOTAL;
    chk({tag, "_count"}, wa_q.size(), TOTAL);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, wa_q[i], i);
      chk({tag, "_data"}, wd_q[i], ecol[i % OUT_W]);
    end
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_timing"}, done_cyc, last_we_cyc + 1);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; invert = 1'b0; thr_en = 1'b0; thresh = '0;
    pix_valid = 1'b0; sof = 1'b0; pix = '0;
    #1;
    chk("reset_we", we, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_waddr", waddr, 0);
    chk("reset_wdata", wdata, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // uniform mid-gray
    clear_mon(); do_start(0, 0, 8'h00);
    send_frame(0, 12'h800, -1, 0, -1, 0);
    check_frame("uniform", 8'h80, 8'h80, 8'h80, 8'h80);

    // column ramp: block means 120,184,248,312 -> top 8 bits 7,11,15,19
    clear_mon(); do_start(0, 0, 8'h00);
    send_frame(1, 12'h000, -1, 0, -1, 0);
    check_frame("ramp", 8'd7, 8'd11, 8'd15, 8'd19);

    clear_mon(); do_start(1, 0, 8'h00);
    send_frame(0, 12'h800, -1, 0, -1, 0);
    check_frame("invert", 8'h7F, 8'h7F, 8'h7F, 8'h7F);

    clear_mon(); do_start(0, 1, 8'h40);
    send_frame(0, 12'h3F0, -1, 0, -1, 0);
    check_frame("thr_low", 8'h00, 8'h00, 8'h00, 8'h00);

    clear_mon(); do_start(0, 1, 8'h40);
    send_frame(0, 12'h400, -1, 0, -1, 0);
    check_frame("thr_high", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

    // early sof on line 12: only block row 0 (lines 5..8) gets written
    clear_mon(); do_start(0, 0, 8'h00);
    send_frame(0, 12'h800, 12, 0, -1, 0);
    chk("sof_err_count", wa_q.size(), OUT_W);
    chk("sof_err_done", done_cnt, 0);
    chk("sof_err_sticky", err, 1);
    chk("sof_err_busy", busy, 0);
    do_start(0, 0, 8'h00);
    chk("err_cleared", err, 0);

    // start already accepted above; stray start mid-frame plus input gaps
    clear_mon();
    send_frame(0, 12'h800, -1, 1, 500, 0);
    check_frame("gaps", 8'h80, 8'h80, 8'h80, 8'h80);

    clear_mon(); do_start(0, 0, 8'h00);
    send_frame(0, 12'h800, -1, 0, -1, 7);
    chk("rst_mid_count", wa_q.size(), 7);
    chk("rst_mid_done", done_cnt, 0);
    clear_mon(); do_start(0, 0, 8'h00);
    send_frame(1, 12'h000, -1, 0, -1, 0);
    check_frame("after_rst", 8'd7, 8'd11, 8'd15, 8'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
